flash_burst_reader: RTL
=======================

# flash_burst_reader

Multi-byte read sequencer sitting directly upstream of the SPI flash byte-read controller. Accepts a (start address, byte length) request, issues one single-byte flash read per address over the controller's valid/ready handshake, and packs the returned bytes little-endian into 32-bit words. Words leave on a valid/ready stream with byte-keep and last flags, feeding key/header loading logic.

## Interface
- LEN_W, 16, width of the request byte count (max burst 2^LEN_W−1 bytes)
- clk  in  1  system clock
- rstn  in  1  synchronous reset, active-high
- req_valid  in  1  burst request strobe
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  24  first flash byte address
- req_len  in  LEN_W  byte count; 0 = no-op
- busy  out  1  burst in progress
- done  out  1  one-cycle completion pulse
- flash_valid  out  1  to flash controller mem_valid
- flash_addr  out  24  to flash controller mem_addr
- flash_data  in  8  from flash controller mem_data
- flash_ready  in  1  from flash controller mem_ready
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts word
- out_data  out  32  packed word; byte k at [8k+7:8k]
- out_keep  out  4  valid byte lanes
- out_last  out  1  final word of burst

## Operation
- States: IDLE, REQ, RELEASE, EMIT, DONE.
- req_ready = (state==IDLE) && !flash_ready (combinational). The !flash_ready term prevents capturing a stale byte from a transaction abandoned by reset.
- IDLE: on accept, latch addr, remaining = req_len, lane = 0, clear out_data/out_keep; busy ← 1. If req_len==0 → DONE, else → REQ.
- REQ: flash_valid = 1, flash_addr = current addr. On flash_ready==1: write flash_data into lane, set out_keep[lane], remaining−1, lane+1, addr+1 (mod 2^24, FFFFFF→000000); flash_valid ← 0; → RELEASE.
- RELEASE: wait flash_ready==0. Then if lane==4 or remaining==0 → EMIT (out_last = remaining==0), else → REQ.
- EMIT: out_valid = 1; out_data/keep/last stable until out_ready. On handshake: clear out_data/out_keep, lane = 0; → DONE if last, else → REQ. No flash read is issued while a word is pending (no overlap).
- DONE: done = 1 for one cycle, busy ← 0, → IDLE.
- Unused lanes of a partial final word are zero; out_keep contiguous from lane 0.
- remaining and lane counters: remaining LEN_W bits, lane 3 bits (0..4).

## Timing
- Reset values: flash_valid 0, flash_addr 0, out_valid 0, out_data 0, out_keep 0, out_last 0, busy 0, done 0, state IDLE; req_ready 1 iff flash_ready 0.
- Reset mid-burst: all outputs at reset values on the next edge; flash_valid dropping lets the controller finish and deassert flash_ready; next request blocked until flash_ready==0.
- flash_valid asserts the cycle after accept (or after RELEASE/EMIT exit); byte captured on the edge where flash_ready is sampled 1.
- out_valid asserts the cycle after RELEASE sees flash_ready==0 with word complete.
- done pulses the cycle after the last word's handshake; len 0: done the cycle after accept.
- req_valid while busy is ignored (req_ready low).

## Structure
- Shared package flash_pkg: FLASH_ADDR_W = 24, WORD_BYTES = 4, state enum for this block.
- One sub-module natural: flash_byte_packer (lane counter, out_data/out_keep accumulation, clear on emit); FSM and address/length counters stay in the top.

## Test plan
- Flash model returns byte = addr[7:0]; req addr 0x000100 len 8 → flash reads 0x100..0x107 in order; words 0x03020100 keep 0xF, 0x07060504 keep 0xF last=1; one done pulse.
- req addr 0x000100 len 6 → second word 0x00000504, keep 0x3, last=1; exactly 6 flash transactions.
- Wrap: addr 0xFFFFFE len 4 → flash_addr FFFFFE, FFFFFF, 000000, 000001; word 0x0100FFFE.
- Backpressure: out_ready low 10 cycles on first word → out_valid/out_data stable, flash_valid stays 0; release → burst completes correctly.
- len 0 → done one cycle after accept; no flash_valid, no out_valid.
- Reset asserted in REQ after 2 bytes → outputs at reset values next edge; with flash_ready held high 3 cycles, req_ready stays 0; new len 4 request then returns correct word.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared definitions for the flash burst read path.
package flash_pkg;
  localparam int FLASH_ADDR_W = 24;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RELEASE,
    S_EMIT,
    S_DONE
  } fbr_state_e;
endpackage

// File: rtl/flash_byte_packer.sv
// Packs single flash bytes little-endian into one output word.
// Tracks the lane count and the matching byte-keep mask.
module flash_byte_packer
  import flash_pkg::*;
(
  input  logic                    clk,
  input  logic                    i_rst,
  input  logic                    i_clr,
  input  logic                    i_wr,
  input  logic [7:0]              i_byte,
  output logic [8*WORD_BYTES-1:0] o_data,
  output logic [WORD_BYTES-1:0]   o_keep,
  output logic [2:0]              o_lane
);

  logic [8*WORD_BYTES-1:0] r_data;
  logic [WORD_BYTES-1:0]   r_keep;
  logic [2:0]              r_lane;

  always_ff @(posedge clk) begin
    if (i_rst || i_clr) begin
      r_data <= '0;
      r_keep <= '0;
      r_lane <= '0;
    end else if (i_wr) begin
      r_data[{r_lane[1:0], 3'b000} +: 8] <= i_byte;
      r_keep[r_lane[1:0]] <= 1'b1;
      r_lane <= r_lane + 3'd1;
    end
  end

  assign o_data = r_data;
  assign o_keep = r_keep;
  assign o_lane = r_lane;

endmodule

// File: rtl/flash_burst_reader.sv
// Multi-byte flash read sequencer: one single-byte read per address,
// bytes packed into 32-bit words on a valid/ready stream.
module flash_burst_reader
  import flash_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [FLASH_ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]        req_len,
  output logic                    busy,
  output logic                    done,
  output logic                    flash_valid,
  output logic [FLASH_ADDR_W-1:0] flash_addr,
  input  logic [7:0]              flash_data,
  input  logic                    flash_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_data,
  output logic [3:0]              out_keep,
  output logic                    out_last
);

  fbr_state_e r_state;
  fbr_state_e w_next;

  logic [FLASH_ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]        r_rem;
  logic                    r_last;

  logic       w_accept;
  logic       w_cap;
  logic       w_clr;
  logic       w_to_emit;
  logic [2:0] w_lane;

  // !flash_ready keeps a byte from an aborted read out of a new burst
  assign req_ready = (r_state == S_IDLE) && !flash_ready;

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_cap     = 1'b0;
    w_clr     = 1'b0;
    w_to_emit = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          w_accept = 1'b1;
          w_clr    = 1'b1;
          w_next   = (req_len == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (flash_ready) begin
          w_cap  = 1'b1;
          w_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!flash_ready) begin
          if (w_lane == 3'd4 || r_rem == '0) begin
            w_to_emit = 1'b1;
            w_next    = S_EMIT;
          end else begin
            w_next = S_REQ;
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          w_clr  = 1'b1;
          w_next = r_last ? S_DONE : S_REQ;
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr <= req_addr;
        r_rem  <= req_len;
        r_last <= 1'b0;
      end
      if (w_cap) begin
        r_addr <= r_addr + 1'b1;
        r_rem  <= r_rem - 1'b1;
      end
      if (w_to_emit) r_last <= (r_rem == '0);
    end
  end

  flash_byte_packer u_packer (
    .clk    (clk),
    .i_rst  (rstn),
    .i_clr  (w_clr),
    .i_wr   (w_cap),
    .i_byte (flash_data),
    .o_data (out_data),
    .o_keep (out_keep),
    .o_lane (w_lane)
  );

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign flash_valid = (r_state == S_REQ);
  assign flash_addr  = r_addr;
  assign out_valid   = (r_state == S_EMIT);
  assign out_last    = r_last;

endmodule
